softmax_max_sub: RTL and testbench

SOFTMAX_MAX_SUB -- requirements
Module: softmax_max_sub

---
 rtl/softmax_max_sub.sv | 137 +++++++++++++
 tb/tb_softmax_max_sub.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_max_sub.sv
// Row max-subtract stage: buffers one row of beats, tracks the signed row max, then streams sat(lane - max).
// Optional sticky forced-termination flag o_ovf when SOFTMAX_MAX_SUB_OVF_EN is defined.
module softmax_max_sub #(
    parameter int N         = 32,
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int MIN_FIXED = -32768
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    input  logic signed [N-1:0][BIT_WIDTH-1:0] i_data,
    input  logic                              i_last,
    output logic                              o_ready,
    output logic signed [N-1:0][BIT_WIDTH-1:0] o_data,
    output logic                              o_valid,
    output logic                              o_last
`ifdef SOFTMAX_MAX_SUB_OVF_EN
    ,
    output logic                              o_ovf
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    localparam logic signed [BIT_WIDTH:0] FLOOR = (BIT_WIDTH + 1)'(MIN_FIXED);

    logic [1:0]                  state;
    logic [CW-1:0]               count;
    logic [CW-1:0]               count_nxt;
    logic [CW-1:0]               rd_ptr;
    logic signed [BIT_WIDTH-1:0] rowmax;
    logic signed [BIT_WIDTH-1:0] beat_max;
    logic signed [BIT_WIDTH-1:0] max_nxt;
    logic [N-1:0][BIT_WIDTH-1:0] mem [DEPTH];
    logic [N-1:0][BIT_WIDTH-1:0] rd_row;
    logic [N-1:0][BIT_WIDTH-1:0] sub;
    logic signed [BIT_WIDTH:0]   diff;
    logic [AW-1:0]               wr_addr;
    logic                        rd_valid;
    logic                        rd_last;
    logic                        accept;
    logic                        row_end;
    logic                        issue;

    assign o_ready   = !i_rst && (state != DRAIN);
    assign accept    = i_valid && o_ready;
    assign count_nxt = (state == IDLE) ? CW'(1) : count + CW'(1);
    assign row_end   = i_last || (count_nxt == CW'(DEPTH));
    assign wr_addr   = (state == IDLE) ? '0 : count[AW-1:0];
    assign issue     = (rd_ptr != count);
    assign max_nxt   = (state == IDLE || beat_max > rowmax) ? beat_max : rowmax;

    always_comb begin
        beat_max = $signed(i_data[0]);
        for (int k = 1; k < N; k++) begin
            if ($signed(i_data[k]) > beat_max) beat_max = $signed(i_data[k]);
        end
    end

    // Difference is taken one bit wider so the full signed range cannot wrap.
    always_comb begin
        sub  = '0;
        diff = '0;
        for (int k = 0; k < N; k++) begin
            diff = $signed({rd_row[k][BIT_WIDTH-1], rd_row[k]})
                 - $signed({rowmax[BIT_WIDTH-1], rowmax});
            if (diff < FLOOR) sub[k] = FLOOR[BIT_WIDTH-1:0];
            else if (!diff[BIT_WIDTH]) sub[k] = '0;
            else sub[k] = diff[BIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) mem[wr_addr] <= i_data;
    end

    // Drain is a two-stage pipe: buffer read, then subtract/saturate into the output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            count    <= '0;
            rowmax   <= '0;
            rd_ptr   <= '0;
            rd_row   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_data   <= '0;
        end else begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        count  <= count_nxt;
                        rowmax <= max_nxt;
                        rd_ptr <= '0;
                        state  <= row_end ? DRAIN : COLLECT;
                    end
                end
                DRAIN: begin
                    rd_valid <= issue;
                    rd_last  <= issue && (rd_ptr == count - CW'(1));
                    if (issue) begin
                        rd_row <= mem[rd_ptr[AW-1:0]];
                        rd_ptr <= rd_ptr + CW'(1);
                    end
                    o_valid <= rd_valid;
                    o_last  <= rd_last;
                    o_data  <= rd_valid ? sub : '0;
                    if (o_valid && o_last) begin
                        state    <= IDLE;
                        count    <= '0;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        o_valid  <= 1'b0;
                        o_last   <= 1'b0;
                        o_data   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOFTMAX_MAX_SUB_OVF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) o_ovf <= 1'b0;
        else if (accept && !i_last && count_nxt == CW'(DEPTH)) o_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_softmax_max_sub.sv
// Bench for softmax_max_sub: table vectors, directed latency/reset/forced-row sequences,
// and random rows against a row-level reference model.
module tb_softmax_max_sub;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int MINF = -32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic lst = 1'b0;
    logic signed [N-1:0][W-1:0] din = '0;
    logic rdy;
    logic ovalid;
    logic olast;
    logic signed [N-1:0][W-1:0] odata;
`ifdef SOFTMAX_MAX_SUB_OVF_EN
    logic ovf;
`endif

    always #5 clk = ~clk;

    softmax_max_sub #(.N(N), .BIT_WIDTH(W), .DEPTH(D), .MIN_FIXED(MINF)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (vld),
        .i_data  (din),
        .i_last  (lst),
        .o_ready (rdy),
        .o_data  (odata),
        .o_valid (ovalid),
        .o_last  (olast)
`ifdef SOFTMAX_MAX_SUB_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    typedef int lanes_t[N];
    typedef struct {
        lanes_t v;
        bit     last;
    } beat_t;
    typedef struct {
        int nb;
        int din[2][N];
        int dout[2][N];
    } vec_t;

    beat_t  got[$];
    beat_t  exp_q[$];
    lanes_t rowq[$];
    vec_t   tbl[4];
    int total = 0;
    int bad = 0;
    int viol_ready = 0;
    int viol_idle = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic string fmt(input beat_t b);
        return $sformatf("{%0d,%0d,%0d,%0d} last=%0d",
                         b.v[0], b.v[1], b.v[2], b.v[3], b.last);
    endfunction

    task automatic chk_beat(input string name, input beat_t a, input beat_t e);
        bit ok;
        ok = (a.last == e.last);
        for (int k = 0; k < N; k++) if (a.v[k] != e.v[k]) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, fmt(a), fmt(e));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ovalid) begin
                beat_t b;
                for (int k = 0; k < N; k++) b.v[k] = $signed(odata[k]);
                b.last = olast;
                got.push_back(b);
                if (rdy) viol_ready++;
            end else if (olast || odata != '0) begin
                viol_idle++;
            end
        end
    end

    function automatic int sat(input int x);
        if (x < MINF) return MINF;
        if (x > 0) return 0;
        return x;
    endfunction

    function automatic void flush_row();
        int mx;
        mx = rowq[0][0];
        foreach (rowq[i]) for (int k = 0; k < N; k++) if (rowq[i][k] > mx) mx = rowq[i][k];
        foreach (rowq[i]) begin
            beat_t b;
            for (int k = 0; k < N; k++) b.v[k] = sat(rowq[i][k] - mx);
            b.last = (i == rowq.size() - 1);
            exp_q.push_back(b);
        end
        rowq.delete();
    endfunction

    // Called at a negedge; holds the beat until accepted, returns at the following negedge.
    task automatic send(input lanes_t v, input bit last);
        int guard = 0;
        vld = 1'b1;
        lst = last;
        for (int k = 0; k < N; k++) din[k] = W'(v[k]);
        while (!rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("ready timeout", 0, 1);
        @(posedge clk);
        rowq.push_back(v);
        if (last || rowq.size() == D) flush_row();
        @(negedge clk);
        vld = 1'b0;
        lst = 1'b0;
    endtask

    task automatic drain_check(input string name);
        int guard = 0;
        while (got.size() < exp_q.size() && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({name, " beats"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk_beat($sformatf("%s beat%0d", name, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    function automatic lanes_t mk(input int a, input int b, input int c, input int d);
        lanes_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic int rnd_lane();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    initial begin
        tbl[0] = '{2, '{'{1, 2, 3, 4}, '{8, 0, -1, 5}},
                      '{'{-7, -6, -5, -4}, '{0, -8, -9, -3}}};
        tbl[1] = '{1, '{'{-32768, 32767, 0, 0}, '{0, 0, 0, 0}},
                      '{'{-32768, 0, -32767, -32767}, '{0, 0, 0, 0}}};
        tbl[2] = '{1, '{'{5, 5, 5, 5}, '{0, 0, 0, 0}},
                      '{'{0, 0, 0, 0}, '{0, 0, 0, 0}}};
        tbl[3] = '{2, '{'{-1, -2, -3, -4}, '{-10, -20, -1, -5}},
                      '{'{0, -1, -2, -3}, '{-9, -19, 0, -4}}};

        repeat (2) @(negedge clk);
        chk("rst o_valid", int'(ovalid), 0);
        chk("rst o_last", int'(olast), 0);
        chk("rst o_data", int'(odata == '0), 1);
        chk("rst o_ready", int'(rdy), 0);
`ifdef SOFTMAX_MAX_SUB_OVF_EN
        chk("rst o_ovf", int'(ovf), 0);
`endif
        rst = 1'b0;
        #1;
        chk("ready after rst", int'(rdy), 1);

        foreach (tbl[i]) begin
            int guard = 0;
            for (int b = 0; b < tbl[i].nb; b++) send(tbl[i].din[b], b == tbl[i].nb - 1);
            while (got.size() < tbl[i].nb && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            repeat (2) @(negedge clk);
            chk($sformatf("tbl%0d beats", i), got.size(), tbl[i].nb);
            for (int b = 0; b < tbl[i].nb && b < got.size(); b++) begin
                beat_t e;
                e.v = tbl[i].dout[b];
                e.last = (b == tbl[i].nb - 1);
                chk_beat($sformatf("tbl%0d beat%0d", i, b), got[b], e);
            end
            got.delete();
            exp_q.delete();
        end

        // Latency: first output on the second rising edge after the accepting edge.
        send(mk(7, -3, 7, 2), 1'b1);
        chk("lat n0 valid", int'(ovalid), 0);
        @(negedge clk);
        chk("lat n1 valid", int'(ovalid), 0);
        chk("lat n1 ready", int'(rdy), 0);
        @(negedge clk);
        chk("lat n2 valid", int'(ovalid), 1);
        chk("lat n2 last", int'(olast), 1);
        @(negedge clk);
        chk("lat n3 valid", int'(ovalid), 0);
        chk("lat n3 ready", int'(rdy), 1);
        drain_check("lat");

        // Forced termination at DEPTH; beats 5..7 held during drain start a fresh row.
        for (int b = 0; b < 7; b++) begin
            if (b < 4) send(mk(100 + b, 50, -b, 3), 1'b0);
            else send(mk(-50 - b, -60, -70, -80 + b), b == 6);
`ifdef SOFTMAX_MAX_SUB_OVF_EN
            chk($sformatf("ovf after beat%0d", b), int'(ovf), int'(b >= 3));
`endif
        end
        drain_check("forced");
`ifdef SOFTMAX_MAX_SUB_OVF_EN
        chk("ovf sticky", int'(ovf), 1);
`endif

        // Reset during the second drain beat of a 3-beat row.
        send(mk(1, 2, 3, 4), 1'b0);
        send(mk(5, 6, 7, 8), 1'b0);
        send(mk(9, 10, 11, 12), 1'b1);
        begin
            int guard = 0;
            while (!ovalid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("rstmid first beat", int'(ovalid), 1);
        end
        @(negedge clk);
        chk("rstmid second beat", int'(ovalid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid valid", int'(ovalid), 0);
        chk("rstmid ready low", int'(rdy), 0);
`ifdef SOFTMAX_MAX_SUB_OVF_EN
        chk("rstmid ovf clr", int'(ovf), 0);
`endif
        rst = 1'b0;
        #1;
        chk("rstmid ready", int'(rdy), 1);
        got.delete();
        exp_q.delete();
        rowq.delete();
        send(mk(-4, 20, 3, -9), 1'b0);
        send(mk(0, 1, 2, 30), 1'b1);
        drain_check("post rst");

        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
                send(mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()),
                     (b == len - 1) && ($urandom_range(0, 3) != 0));
        end
        send(mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()), 1'b1);
        drain_check("random");

        chk("ready low while valid", viol_ready, 0);
        chk("idle outputs zero", viol_idle, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
